countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counter with start/pause/stop control and a one-cycle terminal-count pulse. It is the counting-down counterpart of the team's 4-bit up counter.
- Datapath is a ripple chain of per-bit borrow slices (full subtractor + register), mirroring the up counter's adder + D flip-flop bit-slice structure.
- Used as a programmable delay / event timer feeding control FSMs.

Parameters:
- WIDTH, 4, counter width in bits (min 2)

Ports:
- clk  input  1  clock, all state updates on rising edge
- res  input  1  reset, synchronous, active-high
- load  input  1  load request; copies load_value into count and reload register
- load_value  input  WIDTH  value captured on load
- start  input  1  begin counting down from current count
- pause  input  1  level; freezes count while high
- stop  input  1  abort counting; count is held
- count  output  WIDTH  current count value (registered)
- busy  output  1  high while in RUN or HOLD
- done  output  1  one-cycle pulse when count reaches 0

Behaviour:
- Reset (res=1 at an edge):
  - count=0, reload_reg=0, busy=0, done=0, state=IDLE.
  - Applies from any state, including mid-count.
- Priority at each edge: res > load > stop > start > pause.
- States: IDLE, RUN, HOLD. busy=1 in RUN/HOLD. All outputs are registered.
- load (any state): count<=load_value, reload_reg<=load_value, state<=IDLE, done<=0. A load during RUN/HOLD aborts the count.
- IDLE:
  - start && count!=0 -> RUN.
  - start && count==0 -> ignored; stay IDLE, no done pulse.
  - count holds.
- RUN:
  - pause=0: count<=count-1 at each edge.
  - pause=1: go to HOLD; count holds at this edge.
  - stop: go to IDLE, count holds.
  - start is ignored.
- HOLD:
  - pause=0 -> RUN; decrement resumes on the following edge.
  - stop -> IDLE.
  - count holds.
- Terminal count: in RUN with pause=0 and count==1, the edge sets count<=0, done<=1, state<=IDLE (busy<=0).
- done clears on the next edge unless another terminal event occurs.
- Timing: start sampled at edge e0 -> busy=1 after e0. With count=N and no pause, count decrements at e1..eN; after eN count=0, done=1, busy=0. N cycles from RUN entry to done.
- No wrap-around: the counter never decrements past 0. The borrow out of the MSB slice is unused.
- Arithmetic: WIDTH-bit unsigned subtract of 1 through the slice chain. slice0 subtrahend=1, other slices subtrahend=0, borrow ripples LSB->MSB.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN
- Defined:
  - At terminal count, count<=reload_reg (not 0), done<=1, state stays RUN, busy stays 1.
  - This gives a periodic done pulse every reload_reg cycles.
  - Exits only via stop, load, or res.
  - pause and HOLD behave as without the macro.
- Undefined: behaviour as in Behaviour (stop at 0, return to IDLE). reload_reg may be optimised away.

Decomposition:
- Package countdown_pkg:
  - state enum type (IDLE, RUN, HOLD)
  - default width constant COUNTDOWN_WIDTH=4
- One sub-module, borrow_slice: a 1-bit full subtractor (a, b, borrow_in -> diff, borrow_out) plus its count register with synchronous res and a hold enable.
- The top instantiates WIDTH slices via generate and keeps the FSM and reload_reg in the top.

Test Plan:
- Reset mid-count: load 9, start, 3 edges later res=1 -> next cycle count=0, busy=0, done=0, state IDLE.
- Basic countdown: load 5, start -> count 4,3,2,1,0 on successive edges; done=1 exactly one cycle coinciding with count=0; busy falls the same edge.
- Pause/stop: load 8, start, pause high for 3 cycles after count=6 -> count holds at 6 for 3 cycles, then resumes 5,4...; stop at count=3 -> IDLE, count stays 3, no done; start again -> continues from 3 to 0 with done.
- Boundary and priority:
  - start with count=0 -> no busy, no done.
  - load=1 and start=1 same edge with load_value=4 -> count=4, IDLE.
  - max value load_value=15 -> 15 cycles to done, no wrap.
- COUNTDOWN_AUTO_RELOAD_EN: load 3, start -> count 2,1,3,2,1,3...; done pulses every 3 cycles; busy stays 1; stop -> IDLE. Without the macro the same stimulus gives a single done pulse.

Source files
------------

// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types and defaults for the countdown timer
package countdown_pkg;

  localparam int COUNTDOWN_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer_borrow_slice.sv
// rtl/countdown_timer_borrow_slice.sv - one bit of the count: full subtractor plus its register
module borrow_slice (
  input  logic clk,
  input  logic res,
  input  logic hold,
  input  logic load,
  input  logic load_bit,
  input  logic b,
  input  logic borrow_in,
  output logic q,
  output logic borrow_out
);

  logic q_q;
  logic q_d;
  logic diff;

  // Full subtractor: q_q - b - borrow_in
  always_comb begin
    diff       = q_q ^ b ^ borrow_in;
    borrow_out = (~q_q & b) | (~(q_q ^ b) & borrow_in);
  end

  // Load beats decrement; hold keeps the bit when the counter is not stepping
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_bit;
    end else if (!hold) begin
      q_d = diff;
    end
  end

  // Bit register with synchronous reset
  always_ff @(posedge clk) begin
    if (res) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with run/hold control; COUNTDOWN_AUTO_RELOAD_EN enables periodic reload
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = COUNTDOWN_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] count_w;
  logic             count_zero, count_one;
  logic             dec_en, term;
  logic             slice_load;
  logic [WIDTH-1:0] slice_load_val;
  logic [WIDTH:0]   borrow;
  logic             borrow_unused;

  assign count_zero = (count_w == '0);
  assign count_one  = (count_w == ONE);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;

  // Reload register follows every explicit load
  always_comb begin
    reload_d = reload_q;
    if (load) begin
      reload_d = load_value;
    end
  end

  // Reload register storage
  always_ff @(posedge clk) begin
    if (res) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: load and stop both abort to IDLE ahead of start/pause
  always_comb begin
    state_d = state_q;
    if (load || stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start && !count_zero) state_d = RUN;
        RUN: begin
          if (pause) begin
            state_d = HOLD;
          end else if (count_zero) begin
            state_d = IDLE;
          end else if (count_one) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            state_d = RUN;
`else
            state_d = IDLE;
`endif
          end
        end
        HOLD: if (!pause) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: decrement enable, terminal detect and the slice load path
  always_comb begin
    dec_en         = (state_q == RUN) && !load && !stop && !pause && !count_zero;
    term           = dec_en && count_one;
    slice_load     = load;
    slice_load_val = load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    if (term) begin
      slice_load     = 1'b1;
      slice_load_val = reload_q;
    end
`endif
    done_d = term;
    busy_d = (state_d != IDLE);
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (res) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign borrow[0] = 1'b0;

  // Ripple chain: only bit 0 subtracts 1, higher bits just absorb the borrow
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    borrow_slice u_slice (
      .clk        (clk),
      .res        (res),
      .hold       (~dec_en),
      .load       (slice_load),
      .load_bit   (slice_load_val[i]),
      .b          ((i == 0) ? 1'b1 : 1'b0),
      .borrow_in  (borrow[i]),
      .q          (count_w[i]),
      .borrow_out (borrow[i+1])
    );
  end

  // Borrow out of the MSB never matters: the counter stops before 0 wraps
  assign borrow_unused = borrow[WIDTH];

  assign count = count_w;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - table, directed and randomized checks for countdown_timer
module tb_countdown_timer;

  localparam int W = 4;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         res, load, start, pause, stop;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         busy, done;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .res        (res),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic         res, load;
    logic [W-1:0] lv;
    logic         start, pause, stop;
    logic [W-1:0] e_count;
    logic         e_busy, e_done;
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nerr = 0;

  // Reference model: counting state kept as plain integers
  int m_count = 0;
  int m_reload = 0;
  bit m_running = 0;
  bit m_paused = 0;
  bit m_done = 0;

  function automatic void model_step(bit r, bit l, int lv, bit s, bit p, bit st);
    m_done = 0;
    if (r) begin
      m_count = 0; m_reload = 0; m_running = 0; m_paused = 0;
    end else if (l) begin
      m_count = lv; m_reload = lv; m_running = 0; m_paused = 0;
    end else if (st) begin
      m_running = 0; m_paused = 0;
    end else if (!m_running) begin
      if (s && m_count != 0) m_running = 1;
    end else if (m_paused) begin
      if (!p) m_paused = 0;
    end else if (p) begin
      m_paused = 1;
    end else begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_done = 1;
        if (AR) m_count = m_reload;
        else m_running = 0;
      end
    end
  endfunction

  task automatic drive(bit r, bit l, int lv, bit s, bit p, bit st);
    res = r; load = l; load_value = W'(lv); start = s; pause = p; stop = st;
    @(posedge clk);
    model_step(r, l, lv, s, p, st);
    #1;
  endtask

  task automatic check(string name, int ec, bit eb, bit ed);
    nvec++;
    if (count !== W'(ec) || busy !== eb || done !== ed) begin
      nerr++;
      $display("FAIL %s: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
               name, count, busy, done, ec, eb, ed);
    end
  endtask

  function automatic void add(bit r, bit l, int lv, bit s, bit p, bit st, int ec, bit eb, bit ed);
    vec_t v;
    v.res = r; v.load = l; v.lv = W'(lv); v.start = s; v.pause = p; v.stop = st;
    v.e_count = W'(ec); v.e_busy = eb; v.e_done = ed;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //  res load lv start pause stop | count busy done
    add(1, 0, 0, 0, 0, 0,   0, 0, 0);   // reset
    add(0, 0, 0, 1, 0, 0,   0, 0, 0);   // start at 0 ignored
    add(0, 1, 4, 1, 0, 0,   4, 0, 0);   // load beats start
    add(0, 0, 0, 0, 0, 0,   4, 0, 0);
    add(0, 1, 8, 0, 0, 0,   8, 0, 0);
    add(0, 0, 0, 1, 0, 0,   8, 1, 0);   // RUN entry, no decrement yet
    add(0, 0, 0, 0, 0, 0,   7, 1, 0);
    add(0, 0, 0, 0, 0, 0,   6, 1, 0);
    add(0, 0, 0, 0, 1, 0,   6, 1, 0);   // pause -> HOLD
    add(0, 0, 0, 0, 1, 0,   6, 1, 0);
    add(0, 0, 0, 0, 1, 0,   6, 1, 0);
    add(0, 0, 0, 0, 0, 0,   6, 1, 0);   // HOLD -> RUN
    add(0, 0, 0, 0, 0, 0,   5, 1, 0);
    add(0, 0, 0, 0, 0, 0,   4, 1, 0);
    add(0, 0, 0, 0, 0, 0,   3, 1, 0);
    add(0, 0, 0, 0, 0, 1,   3, 0, 0);   // stop holds count
    add(0, 0, 0, 0, 0, 0,   3, 0, 0);
    add(0, 0, 0, 1, 0, 0,   3, 1, 0);   // restart from 3
    add(0, 0, 0, 0, 0, 0,   2, 1, 0);
    add(0, 0, 0, 1, 0, 1,   2, 0, 0);   // stop beats start
    add(0, 1, 9, 0, 0, 0,   9, 0, 0);
    add(0, 0, 0, 1, 0, 0,   9, 1, 0);
    add(0, 0, 0, 0, 0, 0,   8, 1, 0);
    add(0, 0, 0, 0, 0, 0,   7, 1, 0);
    add(0, 0, 0, 0, 0, 0,   6, 1, 0);
    add(1, 0, 0, 1, 0, 0,   0, 0, 0);   // reset mid-count
    add(0, 0, 0, 1, 0, 0,   0, 0, 0);
    add(0, 1, 2, 0, 0, 1,   2, 0, 0);   // load beats stop
    add(0, 0, 0, 1, 1, 0,   2, 1, 0);   // start beats pause in IDLE
    add(0, 0, 0, 1, 0, 0,   1, 1, 0);   // start ignored in RUN
    add(0, 1, 6, 0, 0, 0,   6, 0, 0);   // load aborts RUN

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].res, tbl[i].load, int'(tbl[i].lv), tbl[i].start, tbl[i].pause, tbl[i].stop);
      check($sformatf("tbl[%0d]", i), int'(tbl[i].e_count), tbl[i].e_busy, tbl[i].e_done);
    end

    // Basic countdown from 5
    drive(0, 1, 5, 0, 0, 0); check("basic_load", 5, 0, 0);
    drive(0, 0, 0, 1, 0, 0); check("basic_start", 5, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 0, 0, 0, 0); check($sformatf("basic_k%0d", k), 5 - k, 1, 0);
    end
    drive(0, 0, 0, 0, 0, 0); check("basic_term", AR ? 5 : 0, AR, 1);
    drive(0, 0, 0, 0, 0, 0); check("basic_after", AR ? 4 : 0, AR, 0);
    drive(0, 0, 0, 0, 0, 1); check("basic_stop", AR ? 4 : 0, 0, 0);

    // Max value: 15 edges to done, never wraps
    drive(0, 1, 15, 0, 0, 0); check("max_load", 15, 0, 0);
    drive(0, 0, 0, 1, 0, 0);  check("max_start", 15, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      if (k < 15) check($sformatf("max_k%0d", k), 15 - k, 1, 0);
      else        check("max_term", AR ? 15 : 0, AR, 1);
    end
    drive(0, 0, 0, 0, 0, 0); check("max_after", AR ? 14 : 0, AR, 0);
    drive(0, 0, 0, 0, 0, 1); check("max_stop", AR ? 14 : 0, 0, 0);

    // Period-3 sequence: periodic with reload, single pulse without
    drive(0, 1, 3, 0, 0, 0); check("per_load", 3, 0, 0);
    drive(0, 0, 0, 1, 0, 0); check("per_start", 3, 1, 0);
    for (int k = 1; k <= 9; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      if (AR) check($sformatf("per_k%0d", k), (k % 3 == 0) ? 3 : 3 - (k % 3), 1, k % 3 == 0);
      else    check($sformatf("per_k%0d", k), (k >= 3) ? 0 : 3 - k, k < 3, k == 3);
    end
    drive(0, 0, 0, 0, 0, 1); check("per_stop", AR ? 3 : 0, 0, 0);

    // Randomized run against the reference model
    drive(1, 0, 0, 0, 0, 0); check("rand_reset", 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      bit r, l, s, p, st;
      int lv;
      r  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 24) == 0);
      s  = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 4) == 0);
      lv = $urandom_range(0, 15);
      drive(r, l, lv, s, p, st);
      check($sformatf("rand[%0d]", i), m_count, m_running, m_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
